// File: rtl/reg_file_8x8.sv
// Multi-ported register file: one synchronous write port and two combinational
// read ports, synchronous active-high clear, no write-through bypass.
module reg_file_8x8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_sel;

  // One-hot write select; an unknown WRITE fails the if test and selects nothing.
  always_comb begin
    wr_sel = '0;
    if (WRITE) begin
      wr_sel[INADDRESS] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_sel[i]) begin
        regs_d[i] = IN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (RESET) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reads come straight from the stored state, so a same-cycle write is not bypassed.
  assign OUT1 = regs_q[OUT1ADDRESS];
  assign OUT2 = regs_q[OUT2ADDRESS];

endmodule

// File: tb/tb_reg_file_8x8.sv
// Directed bench for reg_file_8x8: a vector table for single-edge behaviour plus
// hand-written sequences for read-during-write, reset timing and a full sweep.
module tb_reg_file_8x8;

  logic       clk;
  logic       reset;
  logic       write;
  logic [2:0] in_address;
  logic [7:0] in_data;
  logic [2:0] out1_address;
  logic [2:0] out2_address;
  logic [7:0] out1;
  logic [7:0] out2;

  int checks;
  int errors;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [2:0] ia;
    logic [7:0] din;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t vecs[12];

  reg_file_8x8 dut (
    .CLK        (clk),
    .RESET      (reset),
    .WRITE      (write),
    .INADDRESS  (in_address),
    .IN         (in_data),
    .OUT1ADDRESS(out1_address),
    .OUT2ADDRESS(out2_address),
    .OUT1       (out1),
    .OUT2       (out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%02h), expected %0d (0x%02h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic wr, input logic [2:0] ia,
                       input logic [7:0] din, input logic [2:0] a1, input logic [2:0] a2);
    reset        = rst;
    write        = wr;
    in_address   = ia;
    in_data      = din;
    out1_address = a1;
    out2_address = a2;
  endtask

  // Drive at the falling edge, let one rising edge pass, then sample.
  task automatic cycle(input logic rst, input logic wr, input logic [2:0] ia,
                       input logic [7:0] din, input logic [2:0] a1, input logic [2:0] a2);
    @(negedge clk);
    drive(rst, wr, ia, din, a1, a2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 3'd0);

    //            rst   wr    ia    din     a1    a2    e1      e2
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 8'd0,   3'd0, 3'd7, 8'd0,   8'd0};
    vecs[1]  = '{1'b0, 1'b0, 3'd0, 8'd0,   3'd1, 3'd6, 8'd0,   8'd0};
    vecs[2]  = '{1'b0, 1'b0, 3'd0, 8'd0,   3'd2, 3'd5, 8'd0,   8'd0};
    vecs[3]  = '{1'b0, 1'b0, 3'd0, 8'd0,   3'd3, 3'd4, 8'd0,   8'd0};
    vecs[4]  = '{1'b0, 1'b1, 3'd2, 8'd10,  3'd2, 3'd5, 8'd10,  8'd0};
    vecs[5]  = '{1'b0, 1'b1, 3'd5, 8'd20,  3'd2, 3'd5, 8'd10,  8'd20};
    vecs[6]  = '{1'b0, 1'b0, 3'd2, 8'd99,  3'd2, 3'd5, 8'd10,  8'd20};
    vecs[7]  = '{1'b0, 1'b1, 3'd3, 8'hAB,  3'd3, 3'd3, 8'hAB,  8'hAB};
    vecs[8]  = '{1'b0, 1'b1, 3'd0, 8'h5A,  3'd0, 3'd3, 8'h5A,  8'hAB};
    vecs[9]  = '{1'b1, 1'b1, 3'd7, 8'd55,  3'd7, 3'd2, 8'd0,   8'd0};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 8'd0,   3'd5, 3'd3, 8'd0,   8'd0};
    vecs[11] = '{1'b0, 1'b0, 3'd0, 8'd0,   3'd0, 3'd7, 8'd0,   8'd0};

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].rst, vecs[i].wr, vecs[i].ia, vecs[i].din, vecs[i].a1, vecs[i].a2);
      check($sformatf("vec%0d_out1", i), out1, vecs[i].e1);
      check($sformatf("vec%0d_out2", i), out2, vecs[i].e2);
    end

    // Read-during-write on R4: old value before the edge, new value after.
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd4, 8'd4, 3'd4, 3'd4);
    #1;
    check("rdw_before_out1", out1, 8'd0);
    check("rdw_before_out2", out2, 8'd0);
    @(posedge clk);
    #1;
    check("rdw_after_out1", out1, 8'd4);
    check("rdw_after_out2", out2, 8'd4);

    // Reset pulse entirely between edges must not clear anything.
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd0, 8'd0, 3'd4, 3'd0);
    #1;
    check("midcycle_reset_now", out1, 8'd4);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midcycle_reset_after_edge", out1, 8'd4);

    // Unknown write enable must not disturb R4.
    @(negedge clk);
    drive(1'b0, 1'bx, 3'd4, 8'hFF, 3'd4, 3'd4);
    @(posedge clk);
    #1;
    check("x_write_out1", out1, 8'd4);

    // Reset in the middle of a write sequence, then writes resume at once.
    cycle(1'b0, 1'b1, 3'd1, 8'h11, 3'd1, 3'd6);
    cycle(1'b0, 1'b1, 3'd6, 8'h66, 3'd1, 3'd6);
    check("seq_pre_r1", out1, 8'h11);
    check("seq_pre_r6", out2, 8'h66);
    cycle(1'b1, 1'b1, 3'd2, 8'h22, 3'd1, 3'd6);
    check("seq_rst_r1", out1, 8'h00);
    check("seq_rst_r6", out2, 8'h00);
    cycle(1'b0, 1'b1, 3'd6, 8'h77, 3'd1, 3'd6);
    check("seq_resume_r1", out1, 8'h00);
    check("seq_resume_r6", out2, 8'h77);
    cycle(1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd4);
    check("seq_discard_r2", out1, 8'h00);
    check("seq_cleared_r4", out2, 8'h00);

    // Full sweep: Ri = 8*i+1, then read pairs (i, 7-i) combinationally.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 3'(i), 8'(8 * i + 1), 3'd0, 3'd0);
    end
    @(negedge clk);
    write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      out1_address = 3'(i);
      out2_address = 3'(7 - i);
      #1;
      check($sformatf("sweep_out1_r%0d", i), out1, 8'(8 * i + 1));
      check($sformatf("sweep_out2_r%0d", 7 - i), out2, 8'(8 * (7 - i) + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_8x8.md
REG_FILE_8X8 -- requirements
Module: reg_file_8x8

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 8, meaning the width of each register and data port.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 3, meaning the address width, giving 2**ADDR_WIDTH registers (8 by default).
REQ-003 The block SHALL have port CLK  input  1  system clock; all state updates occur on its rising edge only.
REQ-004 The block SHALL have port RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 The block SHALL have port WRITE  input  1  write enable for the write port.
REQ-006 The block SHALL have port INADDRESS  input  ADDR_WIDTH  destination register index for a write.
REQ-007 The block SHALL have port IN  input  DATA_WIDTH  write data.
REQ-008 The block SHALL have port OUT1ADDRESS  input  ADDR_WIDTH  register index for read port 1.
REQ-009 The block SHALL have port OUT2ADDRESS  input  ADDR_WIDTH  register index for read port 2.
REQ-010 The block SHALL have port OUT1  output  DATA_WIDTH  read data, port 1.
REQ-011 The block SHALL have port OUT2  output  DATA_WIDTH  read data, port 2.

Function
REQ-012 The block SHALL hold 2**ADDR_WIDTH registers of DATA_WIDTH bits, indexed 0 to 2**ADDR_WIDTH-1; register 0 is an ordinary writable register.
REQ-013 The write path SHALL decode INADDRESS one-hot and update only the addressed register; all other registers hold their value.
REQ-014 On a rising CLK edge with RESET=0 and WRITE=1, the register at INADDRESS SHALL take the value of IN.
REQ-015 On a rising CLK edge with RESET=0 and WRITE=0, no register SHALL change, whatever the values of IN and INADDRESS.
REQ-016 Reads SHALL be combinational with no clock latency: OUT1 SHALL equal register[OUT1ADDRESS] and OUT2 SHALL equal register[OUT2ADDRESS] in the same cycle.
REQ-017 Both read ports SHALL be independent; OUT1ADDRESS equal to OUT2ADDRESS SHALL drive the same value on both outputs.
REQ-018 Read-during-write to the same address SHALL return the old contents until the rising edge, then the new contents; there SHALL be no write-through bypass.
REQ-019 The write data SHALL first be visible on OUTx in the cycle after the rising edge that writes it (one-cycle write-to-read latency).
REQ-020 IN and INADDRESS SHALL only be sampled at the rising edge; glitches between edges SHALL have no effect.
REQ-021 Any X or Z on WRITE SHALL not corrupt registers in RTL simulation; an X on WRITE SHALL be treated as no write.

Reset
REQ-022 On a rising CLK edge with RESET=1, every register SHALL be cleared to 0, and OUT1 and OUT2 SHALL read 0 from that edge onward.
REQ-023 RESET SHALL take priority over WRITE; a write requested in a reset cycle SHALL be discarded.
REQ-024 Asserting RESET between clock edges SHALL have no effect until the next rising edge (no asynchronous clear).
REQ-025 Reset asserted in the middle of a write sequence SHALL clear all registers, including ones written earlier in the sequence; writes SHALL resume normally in the first cycle with RESET=0.
REQ-026 Before the first reset, register contents SHALL be undefined; the bench SHALL NOT check outputs before the first reset.

Verification
REQ-027 Reset: RESET=1 for one edge, then read all 8 addresses on both ports -> every read returns 0.
REQ-028 Write/read: write 10 to R2 and 20 to R5 in consecutive cycles; then OUT1ADDRESS=2, OUT2ADDRESS=5 -> OUT1=10, OUT2=20.
REQ-029 Write disabled: WRITE=0, IN=99, INADDRESS=2 for one edge -> OUT1 (address 2) stays 10.
REQ-030 Read-during-write: OUT1ADDRESS=4 with R4=0; write 4 to R4 -> OUT1=0 before the edge and 4 after it; OUT2ADDRESS=4 also shows 4.
REQ-031 Reset priority: RESET=1 and WRITE=1 with IN=55 and INADDRESS=7 on the same edge -> R7=0 and all registers are 0.
REQ-032 Full sweep: write value 8*i+1 to each Ri for i=0..7, then read all pairs (i, 7-i) -> OUT1=8*i+1 and OUT2=8*(7-i)+1.
